viterbi_depuncturer: RTL and testbench
======================================

Name: viterbi_depuncturer

Overview:
- Receive-side counterpart of the transmit convolutional encoder and puncturer.
- Takes the serial, punctured coded-bit stream and rebuilds the rate-1/2 (A,B) symbol pairs per 802.11a puncturing, flagging the punctured positions as erasures.
- Feeds the Viterbi branch-metric unit through a small ready/valid output FIFO.
- Punctured-bit order matches the encoder exactly: A first, then B, within each pair.

Parameters:
- DEPTH, 8, output FIFO depth in pairs (power of two, >=4).
- LVL_W, 4, width of fifo_level; must hold DEPTH (log2(DEPTH)+1).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- mode  in  2  0 = r1/2, 1 = r3/4, 2 = r2/3, 3 = treated as r1/2.
- sync  in  1  period-alignment pulse; marks the current bit as phase 0.
- data_in  in  1  serial coded bit.
- inputValid  in  1  data_in valid this cycle; no backpressure to source.
- data_out  out  2  [0] = A bit, [1] = B bit; erased positions read 0.
- erase_out  out  2  [0] = A erased, [1] = B erased.
- outputValid  out  1  FIFO non-empty (FWFT head valid).
- outputReady  in  1  consumer accepts head this cycle.
- fifo_level  out  LVL_W  entries currently held.
- overflow  out  1  sticky: a pair was dropped because the FIFO was full.

Behaviour:
- Reset (reset == 0 at a clock edge): phase = 0, held A bit = 0, FIFO empty, data_out = 0, erase_out = 0, outputValid = 0, fifo_level = 0, overflow = 0. Reset overrides all other inputs; a reset mid-period discards any partial pair.
- Phase counter (2 bits) advances only on accepted bits (inputValid = 1).
- Mode is latched into the active mode register only when a bit is accepted at phase 0. A mode change mid-period takes effect at the next period start.
- r1/2, period 2:
  - ph0: hold A.
  - ph1: push (A, B = bit), erase = 00; phase -> 0.
- r2/3, period 3:
  - ph0: hold A0.
  - ph1: push (A0, B0), erase 00.
  - ph2: push (A1 = bit, B = 0), erase = 10; phase -> 0.
- r3/4, period 4:
  - ph0: hold A0.
  - ph1: push (A0, B0), erase 00.
  - ph2: push (A1, 0), erase 10.
  - ph3: push (0, B2), erase 01; phase -> 0.
- At most one push per cycle in every mode.
- sync:
  - sync = 1 with inputValid = 1: the bit is processed as phase 0 (mode latched) and any partial pair is discarded.
  - sync = 1 with inputValid = 0: phase -> 0, held A cleared, nothing pushed.
- Latency: a push occurs at the edge that samples the completing bit. outputValid, data_out and erase_out reflect the entry from the next cycle onward (1-cycle latency when the FIFO was empty).
- FIFO behaviour:
  - First-word-fall-through; pop occurs when outputValid && outputReady.
  - Push and pop in the same cycle: level unchanged, order preserved.
  - Push while full with no pop: pair dropped, overflow = 1 until reset, level stays DEPTH.
  - Push while full with a pop in the same cycle: push accepted.
  - Pop while empty: ignored.
  - Read/write pointers wrap modulo DEPTH.
- When outputValid = 0, data_out and erase_out are 0.
- Throughput: with outputReady held at 1, the FIFO never exceeds 1 entry in any mode.

Test Plan:
- r1/2: reset, then bits 1,0,1,1 with outputReady = 1 -> pairs (A=1,B=0,e=00), (1,1,00); each outputValid one cycle after the 2nd/4th bit; overflow = 0.
- r3/4: bits 1,1,0,1 -> pairs (1,1,00), (0,0,10), (0,1,01) on three consecutive cycles; r2/3: bits 0,1,1 -> (0,1,00), (1,0,10).
- Backpressure: r1/2, outputReady = 0, 2*DEPTH+2 bits -> fifo_level saturates at DEPTH, overflow = 1; then outputReady = 1 drains exactly DEPTH pairs in arrival order with correct pointer wrap.
- sync/mode: r3/4, send 2 bits, change mode to 0 -> next 2 bits still follow r3/4 phases; then sync with bit 1, next bit 0 -> pair (1,0,00) under r1/2.
- Reset mid-period: r2/3, 1 bit, reset low for one cycle, then bits 1,0,1 -> outputs (1,0,00), (1,0,10) only, with no stale A; all outputs 0 during reset.
- Simultaneous push/pop at full: fill the FIFO, then raise outputReady on the same edge a pair completes -> fifo_level stays DEPTH, overflow stays 0.

Source files
------------

// File: rtl/viterbi_depuncturer.sv
// Rebuilds rate-1/2 (A,B) pairs from a punctured 802.11a bit stream, marks
// punctured positions as erasures and buffers pairs in a small FWFT FIFO.
module viterbi_depuncturer #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             sync,
  input  logic             data_in,
  input  logic             inputValid,
  output logic [1:0]       data_out,
  output logic [1:0]       erase_out,
  output logic             outputValid,
  input  logic             outputReady,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  // state | meaning
  // PH0   | period start: latch mode, hold A
  // PH1   | complete first (A,B) pair
  // PH2   | r2/3, r3/4: A-only pair (B punctured)
  // PH3   | r3/4: B-only pair (A punctured)
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  localparam int PTR_W = $clog2(DEPTH);

  phase_e     phase_q, phase_d, cur_phase;
  logic       a_q, a_d;
  logic [1:0] mode_q, mode_d, cur_mode;
  logic       is_r34, is_r23;
  logic       push;
  logic [1:0] push_data, push_erase;

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q <= PH0;
      a_q     <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    a_d        = a_q;
    mode_d     = mode_q;
    push       = 1'b0;
    push_data  = 2'b00;
    push_erase = 2'b00;
    // A sync forces the current bit to be treated as the start of a period.
    cur_phase  = sync ? PH0 : phase_q;
    cur_mode   = (cur_phase == PH0) ? mode : mode_q;
    is_r34     = (cur_mode == 2'd1);
    is_r23     = (cur_mode == 2'd2);
    if (inputValid) begin
      case (cur_phase)
        PH0: begin
          mode_d  = mode;
          a_d     = data_in;
          phase_d = PH1;
        end
        PH1: begin
          push      = 1'b1;
          push_data = {data_in, a_q};
          phase_d   = (is_r34 || is_r23) ? PH2 : PH0;
        end
        PH2: begin
          push       = 1'b1;
          push_data  = {1'b0, data_in};
          push_erase = 2'b10;
          phase_d    = is_r34 ? PH3 : PH0;
        end
        PH3: begin
          push       = 1'b1;
          push_data  = {data_in, 1'b0};
          push_erase = 2'b01;
          phase_d    = PH0;
        end
      endcase
    end else if (sync) begin
      phase_d = PH0;
      a_d     = 1'b0;
    end
  end

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fifo_empty, fifo_full, pop, wr_en;
  logic [3:0]       head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == LVL_W'(DEPTH));
  assign pop        = !fifo_empty && outputReady;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign wr_en      = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      count_d = count_q + LVL_W'(1);
    else if (!wr_en && pop) count_d = count_q - LVL_W'(1);
    if (push && !wr_en) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && wr_en) mem_q[wr_ptr_q] <= {push_erase, push_data};
  end

  assign head        = mem_q[rd_ptr_q];
  assign outputValid = !fifo_empty;
  assign data_out    = fifo_empty ? 2'b00 : head[1:0];
  assign erase_out   = fifo_empty ? 2'b00 : head[3:2];
  assign fifo_level  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_viterbi_depuncturer.sv
// Self-checking bench for viterbi_depuncturer: directed scenarios plus random
// traffic compared against a queue-based depuncture/FIFO reference model.
module tb_viterbi_depuncturer;
  localparam int DEPTH = 8;
  localparam int LVL_W = 4;

  logic             clock = 1'b0;
  logic             reset, sync, data_in, inputValid, outputReady;
  logic [1:0]       mode;
  logic [1:0]       data_out, erase_out;
  logic             outputValid, overflow;
  logic [LVL_W-1:0] fifo_level;

  int tests = 0;
  int fails = 0;

  // reference model: expected FIFO contents {erase, B, A}, overflow flag,
  // bits of the current puncturing period and that period's length
  logic [3:0] mq[$];
  bit         m_ovf;
  bit         pb[$];
  int         plen;

  always #5 clock = ~clock;

  viterbi_depuncturer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clock(clock), .reset(reset), .mode(mode), .sync(sync),
    .data_in(data_in), .inputValid(inputValid), .data_out(data_out),
    .erase_out(erase_out), .outputValid(outputValid),
    .outputReady(outputReady), .fifo_level(fifo_level), .overflow(overflow)
  );

  function automatic logic [9:0] dut_vec();
    return {outputValid, data_out, erase_out, fifo_level, overflow};
  endfunction

  function automatic logic [9:0] mdl_vec();
    logic       v;
    logic [3:0] h;
    v = (mq.size() != 0);
    h = v ? mq[0] : 4'b0;
    return {v, h[1:0], h[3:2], LVL_W'(mq.size()), m_ovf};
  endfunction

  task automatic model_edge(input bit v, input bit b, input bit s,
                            input logic [1:0] m, input bit rdy);
    bit         pop, have;
    logic [3:0] ent;
    int         k;
    pop  = (mq.size() != 0) && rdy;
    have = 1'b0;
    ent  = 4'b0;
    if (s) pb.delete();
    if (v) begin
      if (pb.size() == 0) plen = (m == 2'd1) ? 4 : (m == 2'd2) ? 3 : 2;
      pb.push_back(b);
      k = pb.size();
      case (k)
        2: begin have = 1'b1; ent = {2'b00, pb[1], pb[0]}; end
        3: begin have = 1'b1; ent = {2'b10, 1'b0, pb[2]}; end
        4: begin have = 1'b1; ent = {2'b01, pb[3], 1'b0}; end
        default: have = 1'b0;
      endcase
      if (k == plen) pb.delete();
    end
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit v, input bit b, input bit s,
                      input logic [1:0] m, input bit rdy);
    reset = 1'b1; inputValid = v; data_in = b; sync = s; mode = m;
    outputReady = rdy;
    @(posedge clock);
    model_edge(v, b, s, m, rdy);
    @(negedge clock);
  endtask

  task automatic rst();
    reset = 1'b0; inputValid = 1'b1; data_in = 1'b1; sync = 1'b0;
    outputReady = 1'b1;
    @(posedge clock);
    mq.delete(); pb.delete(); m_ovf = 1'b0; plen = 2;
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst();
    tests++;
    if (dut_vec() !== 10'b0) begin
      fails++; $display("FAIL reset_state got %b exp %b", dut_vec(), 10'b0);
    end
  endtask

  task automatic test_r12();
    logic [4:0] exp_o [4];
    bit         bits [4];
    exp_o = '{5'b0, {1'b1, 2'b01, 2'b00}, 5'b0, {1'b1, 2'b11, 2'b00}};
    bits  = '{1'b1, 1'b0, 1'b1, 1'b1};
    rst();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[i], 1'b0, 2'd0, 1'b1);
      tests++;
      if ({outputValid, data_out, erase_out, overflow} !== {exp_o[i], 1'b0}) begin
        fails++;
        $display("FAIL r12 bit%0d got %b exp %b", i,
                 {outputValid, data_out, erase_out, overflow}, {exp_o[i], 1'b0});
      end
    end
  endtask

  task automatic test_r34_r23();
    logic [4:0] e34 [4];
    logic [4:0] e23 [3];
    bit         b34 [4];
    bit         b23 [3];
    e34 = '{5'b0, {1'b1, 2'b11, 2'b00}, {1'b1, 2'b00, 2'b10}, {1'b1, 2'b10, 2'b01}};
    b34 = '{1'b1, 1'b1, 1'b0, 1'b1};
    e23 = '{5'b0, {1'b1, 2'b10, 2'b00}, {1'b1, 2'b01, 2'b10}};
    b23 = '{1'b0, 1'b1, 1'b1};
    rst();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b34[i], 1'b0, 2'd1, 1'b1);
      tests++;
      if ({outputValid, data_out, erase_out} !== e34[i]) begin
        fails++;
        $display("FAIL r34 bit%0d got %b exp %b", i,
                 {outputValid, data_out, erase_out}, e34[i]);
      end
    end
    rst();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b23[i], 1'b0, 2'd2, 1'b1);
      tests++;
      if ({outputValid, data_out, erase_out} !== e23[i]) begin
        fails++;
        $display("FAIL r23 bit%0d got %b exp %b", i,
                 {outputValid, data_out, erase_out}, e23[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    rst();
    // pre-advance the pointers so the fill wraps past the end of the array
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom), 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      step(1'b1, 1'($urandom), 1'b0, 2'd0, 1'b0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL bp_fill cyc%0d got %b exp %b", i, dut_vec(), mdl_vec());
      end
    end
    tests++;
    if ({fifo_level, overflow} !== {LVL_W'(DEPTH), 1'b1}) begin
      fails++;
      $display("FAIL bp_saturate got lvl=%0d ovf=%b exp lvl=%0d ovf=1",
               fifo_level, overflow, DEPTH);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL bp_drain cyc%0d got %b exp %b", i, dut_vec(), mdl_vec());
      end
    end
    tests++;
    if ({outputValid, fifo_level, overflow} !== {1'b0, LVL_W'(0), 1'b1}) begin
      fails++;
      $display("FAIL bp_empty got v=%b lvl=%0d ovf=%b exp v=0 lvl=0 ovf=1",
               outputValid, fifo_level, overflow);
    end
  endtask

  task automatic test_sync_mode();
    rst();
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    tests++;
    if (dut_vec() !== mdl_vec()) begin
      fails++; $display("FAIL mode_midperiod got %b exp %b", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    tests++;
    if ({outputValid, data_out, erase_out} !== {1'b1, 2'b01, 2'b00}) begin
      fails++;
      $display("FAIL sync_bit got %b exp %b", {outputValid, data_out, erase_out},
               {1'b1, 2'b01, 2'b00});
    end
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    tests++;
    if (dut_vec() !== mdl_vec()) begin
      fails++; $display("FAIL sync_idle got %b exp %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_reset_mid();
    bit         bits [3];
    logic [4:0] exp_o [3];
    bits  = '{1'b1, 1'b0, 1'b1};
    exp_o = '{5'b0, {1'b1, 2'b01, 2'b00}, {1'b1, 2'b01, 2'b10}};
    rst();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    rst();
    tests++;
    if (dut_vec() !== 10'b0) begin
      fails++; $display("FAIL reset_mid_outputs got %b exp %b", dut_vec(), 10'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, bits[i], 1'b0, 2'd2, 1'b1);
      tests++;
      if ({outputValid, data_out, erase_out, overflow} !== {exp_o[i], 1'b0}) begin
        fails++;
        $display("FAIL reset_mid bit%0d got %b exp %b", i,
                 {outputValid, data_out, erase_out, overflow}, {exp_o[i], 1'b0});
      end
    end
  endtask

  task automatic test_full_pushpop();
    rst();
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, 1'($urandom), 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    tests++;
    if ({fifo_level, overflow} !== {LVL_W'(DEPTH), 1'b0}) begin
      fails++;
      $display("FAIL full_pushpop got lvl=%0d ovf=%b exp lvl=%0d ovf=0",
               fifo_level, overflow, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL full_drain cyc%0d got %b exp %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    bit         v, s, r;
    logic [1:0] m;
    rst();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 2) != 0);
      m = 2'($urandom);
      step(v, 1'($urandom), s, m, r);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL random cyc%0d got %b exp %b", i, dut_vec(), mdl_vec());
      end
    end
    rst();
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'($urandom), ($urandom_range(0, 15) == 0), 2'($urandom), 1'b1);
      tests++;
      if (dut_vec() !== mdl_vec() || fifo_level > LVL_W'(1)) begin
        fails++;
        $display("FAIL throughput cyc%0d got %b exp %b (level<=1)", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0; sync = 1'b0; data_in = 1'b0; inputValid = 1'b0;
    outputReady = 1'b0; mode = 2'd0; m_ovf = 1'b0; plen = 2;
    @(negedge clock);
    test_reset();
    test_r12();
    test_r34_r23();
    test_backpressure();
    test_sync_mode();
    test_reset_mid();
    test_full_pushpop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
